// File: rtl/key_led_pkg.sv
// Shared constants and helpers for the key/LED front end.
// Optional blink feature is selected with the KEY_LED_BLINK_EN macro in key_led_ctrl.
package key_led_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  localparam int DEF_SCAN_DIV  = 1_000_000;
  localparam int DEF_DB_CNT    = 3;
  localparam int DEF_BLINK_DIV = 50_000_000;

  // Counter width helper: never returns 0 so tiny parameters still give a legal vector.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// One key channel: 2-flop synchroniser, scan-tick debouncer, debounced level and press pulse.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DB_CNT = DEF_DB_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  input  logic scan_tick_i,
  output logic key_state_o,
  output logic press_pulse_o
);

  localparam int             CW       = clog2_min1(DB_CNT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic          state_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // The differing sample that would bring cnt to DB_CNT is accepted directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (scan_tick_i) begin
      if (sync2_q != state_q) begin
        if (cnt_q == CNT_LAST) begin
          state_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign pulse_d = state_dly_q & ~state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= 1'b1;
      state_dly_q <= 1'b1;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= key_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      state_dly_q <= state_q;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
    end
  end

  assign key_state_o   = state_q;
  assign press_pulse_o = pulse_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Multi-channel key debouncer with per-channel toggle/momentary LED drive.
// Define KEY_LED_BLINK_EN to add the blink_en port and the shared blink counter.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DB_CNT         = DEF_DB_CNT,
  parameter int LED_ACTIVE_LOW = 1,
  parameter int BLINK_DIV      = DEF_BLINK_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] key_in,
  input  logic [N_CH-1:0] mode,
`ifdef KEY_LED_BLINK_EN
  input  logic [N_CH-1:0] blink_en,
`endif
  output logic [N_CH-1:0] key_state,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] led_out
);

  if (N_CH < 1 || N_CH > 16 || SCAN_DIV < 2 || DB_CNT < 1 || DB_CNT > 15 || BLINK_DIV < 1)
  begin : g_param_check
    $error("key_led_ctrl: parameter out of range");
  end

  localparam int            PW        = clog2_min1(SCAN_DIV);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic            scan_tick;
  logic [N_CH-1:0] led_lit_q, led_lit_d;
  logic [N_CH-1:0] lit_eff;

  assign scan_tick = (presc_q == SCAN_LAST);
  assign presc_d   = scan_tick ? '0 : presc_q + PW'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    key_debounce #(
      .DB_CNT(DB_CNT)
    ) u_db (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_i        (key_in[i]),
      .scan_tick_i  (scan_tick),
      .key_state_o  (key_state[i]),
      .press_pulse_o(press_pulse[i])
    );
  end

  // Mode only selects the update rule, so a mode change keeps the current lit state.
  always_comb begin
    led_lit_d = led_lit_q;
    for (int i = 0; i < N_CH; i++) begin
      if (mode[i] == MODE_MOMENTARY) begin
        led_lit_d[i] = ~key_state[i];
      end else if (press_pulse[i]) begin
        led_lit_d[i] = ~led_lit_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      led_lit_q <= '0;
    end else begin
      presc_q   <= presc_d;
      led_lit_q <= led_lit_d;
    end
  end

`ifdef KEY_LED_BLINK_EN
  localparam int            BW         = clog2_min1(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign lit_eff = led_lit_q & ~(blink_en & ~{N_CH{blink_phase_q}});
`else
  assign lit_eff = led_lit_q;
`endif

  assign led_out = (LED_ACTIVE_LOW != 0) ? ~lit_eff : lit_eff;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl: vector table plus hand sequences for timing corners.
module tb_key_led_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] mode;
  logic [3:0] blink_en;
  logic [3:0] key_state;
  logic [3:0] press_pulse;
  logic [3:0] led_out;

  int total = 0;
  int bad   = 0;

  key_led_ctrl #(
    .N_CH          (4),
    .SCAN_DIV      (4),
    .DB_CNT        (3),
    .LED_ACTIVE_LOW(1),
    .BLINK_DIV     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .mode       (mode),
`ifdef KEY_LED_BLINK_EN
    .blink_en   (blink_en),
`endif
    .key_state  (key_state),
    .press_pulse(press_pulse),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [3:0] mode;
    logic [3:0] exp_state;
    logic [3:0] exp_led;
    logic [3:0] exp_pulse;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] k, input logic [3:0] m,
                         input logic [3:0] s, input logic [3:0] l, input logic [3:0] p);
    vecs[i].key       = k;
    vecs[i].mode      = m;
    vecs[i].exp_state = s;
    vecs[i].exp_led   = l;
    vecs[i].exp_pulse = p;
  endtask

  initial begin
    int         pcnt[4];
    logic [7:0] got_p, exp_p;
    int         n;
    int         errs;
    logic       seen;
    logic       cur;

    set_vec(0,  4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    set_vec(1,  4'b1110, 4'b0000, 4'b1110, 4'b1110, 4'b0001);
    set_vec(2,  4'b1111, 4'b0000, 4'b1111, 4'b1110, 4'b0000);
    set_vec(3,  4'b1110, 4'b0000, 4'b1110, 4'b1111, 4'b0001);
    set_vec(4,  4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    set_vec(5,  4'b0110, 4'b0000, 4'b0110, 4'b0110, 4'b1001);
    set_vec(6,  4'b1111, 4'b0000, 4'b1111, 4'b0110, 4'b0000);
    set_vec(7,  4'b1111, 4'b0100, 4'b1111, 4'b0110, 4'b0000);
    set_vec(8,  4'b1011, 4'b0100, 4'b1011, 4'b0010, 4'b0100);
    set_vec(9,  4'b1111, 4'b0100, 4'b1111, 4'b0110, 4'b0000);
    set_vec(10, 4'b0111, 4'b0000, 4'b0111, 4'b1110, 4'b1000);
    set_vec(11, 4'b1111, 4'b0000, 4'b1111, 4'b1110, 4'b0000);
    set_vec(12, 4'b1111, 4'b0001, 4'b1111, 4'b1111, 4'b0000);
    set_vec(13, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

    // reset with keys held low
    rst_n    = 1'b0;
    key_in   = 4'b0000;
    mode     = 4'b0000;
    blink_en = 4'b0000;
    repeat (5) step();
    check("reset_led_out", led_out, 4'b1111);
    check("reset_key_state", key_state, 4'b1111);
    check("reset_press_pulse", press_pulse, 4'b0000);
    key_in = 4'b1111;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // vector table
    for (int i = 0; i < 14; i++) begin
      key_in = vecs[i].key;
      mode   = vecs[i].mode;
      for (int c = 0; c < 4; c++) pcnt[c] = 0;
      for (int t = 0; t < 24; t++) begin
        step();
        for (int c = 0; c < 4; c++) if (press_pulse[c]) pcnt[c]++;
      end
      for (int c = 0; c < 4; c++) begin
        got_p[2*c +: 2] = (pcnt[c] > 3) ? 2'd3 : 2'(pcnt[c]);
        exp_p[2*c +: 2] = {1'b0, vecs[i].exp_pulse[c]};
      end
      check($sformatf("vec%0d_key_state", i), key_state, vecs[i].exp_state);
      check($sformatf("vec%0d_led_out", i), led_out, vecs[i].exp_led);
      check($sformatf("vec%0d_pulse_counts", i), got_p, exp_p);
    end

    // simultaneous press on ch0 and ch3 must pulse in the same cycle
    key_in = 4'b0110;
    n = 0;
    while (press_pulse == 4'b0000 && n < 30) begin
      step();
      n++;
    end
    check("simul_pulse_vec", press_pulse, 4'b1001);
    step();
    check("simul_pulse_width", press_pulse, 4'b0000);
    key_in = 4'b1111;
    repeat (24) step();
    mode = 4'b1001;
    step();
    mode = 4'b0000;
    step();

    // momentary channel 2: LED follows key_state one clk later, no release pulse
    mode   = 4'b0100;
    key_in = 4'b1011;
    n = 0;
    while (key_state[2] !== 1'b0 && n < 30) begin
      step();
      n++;
    end
    check("mom_fall_seen", key_state[2], 1'b0);
    check("mom_led_at_fall", led_out[2], 1'b1);
    step();
    check("mom_led_fall_plus1", led_out[2], 1'b0);
    repeat (20) step();
    key_in = 4'b1111;
    seen = 1'b0;
    n = 0;
    while (key_state[2] !== 1'b1 && n < 30) begin
      step();
      n++;
      if (press_pulse[2]) seen = 1'b1;
    end
    check("mom_rise_seen", key_state[2], 1'b1);
    check("mom_led_at_rise", led_out[2], 1'b0);
    step();
    check("mom_led_rise_plus1", led_out[2], 1'b1);
    repeat (10) begin
      step();
      if (press_pulse[2]) seen = 1'b1;
    end
    check("mom_no_release_pulse", seen, 1'b0);
    mode = 4'b0000;
    step();

    // bounce on channel 1 never reaches three agreeing ticks
    seen = 1'b0;
    errs = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) key_in[1] = ~key_in[1];
      step();
      if (press_pulse[1]) seen = 1'b1;
      if (key_state[1] !== 1'b1) errs++;
    end
    key_in = 4'b1111;
    repeat (20) begin
      step();
      if (press_pulse[1]) seen = 1'b1;
    end
    check("bounce_no_pulse", seen, 1'b0);
    check("bounce_state_stable", errs, 0);
    check("bounce_led1_off", led_out[1], 1'b1);

    // press latency: 2 sync + 3 ticks (phase dependent) + 1 registered pulse
    key_in = 4'b1110;
    n = 0;
    while (press_pulse[0] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("press_latency_in_12_to_15", (n >= 12 && n <= 15), 1'b1);
    step();
    check("latency_led_toggled", led_out, 4'b1110);
    key_in = 4'b1111;
    repeat (24) step();

    // reset mid-debounce aborts the count; held key needs 3 full ticks afterwards
    key_in = 4'b1101;
    seen = 1'b0;
    repeat (9) begin
      step();
      if (press_pulse[1]) seen = 1'b1;
    end
    check("pre_reset_no_pulse", seen, 1'b0);
    check("pre_reset_state", key_state[1], 1'b1);
    rst_n = 1'b0;
    repeat (2) step();
    check("midreset_key_state", key_state, 4'b1111);
    check("midreset_led_out", led_out, 4'b1111);
    check("midreset_pulse", press_pulse, 4'b0000);
    rst_n = 1'b1;
    n = 0;
    while (press_pulse[1] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("post_reset_latency", n, 13);
    step();
    check("post_reset_led", led_out, 4'b1101);
    key_in = 4'b1111;
    repeat (24) step();

`ifdef KEY_LED_BLINK_EN
    // ch0 lit and blinking: output flips every 8 clk
    key_in = 4'b1110;
    repeat (24) step();
    check("blink_ch0_lit", led_out[0], 1'b0);
    blink_en = 4'b0001;
    step();
    cur = led_out[0];
    n = 0;
    while (led_out[0] === cur && n < 20) begin
      step();
      n++;
    end
    check("blink_first_edge", (n >= 1 && n <= 8), 1'b1);
    for (int h = 0; h < 3; h++) begin
      cur  = led_out[0];
      errs = 0;
      for (int k = 1; k < 8; k++) begin
        step();
        if (led_out[0] !== cur) errs++;
      end
      check($sformatf("blink_hold_%0d", h), errs, 0);
      step();
      check($sformatf("blink_flip_%0d", h), led_out[0], ~cur);
    end
    blink_en = 4'b0000;
    errs = 0;
    repeat (16) begin
      step();
      if (led_out[0] !== 1'b0) errs++;
    end
    check("blink_off_steady", errs, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
